mem_arbiter: RTL

//  Shares the single external memory port between I-cache refills and D-cache refills/write-backs.

---
 rtl/mem_arbiter_pkg.sv | 11 +
 rtl/mem_arbiter_arb_pick.sv | 38 +++
 rtl/mem_arbiter.sv | 107 ++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and default widths for the memory-port arbiter.
// Optional round-robin tie-breaking is selected by the ARB_RR_EN macro (see arb_pick).
package mem_arbiter_pkg;

   localparam int unsigned ADDR_W_DEFAULT = 28;
   localparam int unsigned LINE_W_DEFAULT = 128;

   typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, RESP} state_t;
   typedef enum logic [1:0] {GR_NONE, GR_IC, GR_DC} grant_t;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Combinational requester picker. ARB_RR_EN defined: alternate on ties using last_grant;
// otherwise the D-cache always wins a tie.
module arb_pick
   import mem_arbiter_pkg::*;
(
   input  logic   ic_req,
   input  logic   dc_req,
   input  grant_t last_grant,
   output grant_t grant
);

`ifdef ARB_RR_EN
   always_comb begin
      grant = GR_NONE;
      if (ic_req && dc_req) begin
         grant = (last_grant == GR_IC) ? GR_DC : GR_IC;
      end else if (dc_req) begin
         grant = GR_DC;
      end else if (ic_req) begin
         grant = GR_IC;
      end
   end
`else
   // History is irrelevant under fixed priority.
   logic unused_last_grant;
   assign unused_last_grant = ^last_grant;

   always_comb begin
      grant = GR_NONE;
      if (dc_req) begin
         grant = GR_DC;
      end else if (ic_req) begin
         grant = GR_IC;
      end
   end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing the memory port between I-cache and D-cache refills/write-backs.
// Tie-breaking policy follows the ARB_RR_EN macro, evaluated inside arb_pick.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
   parameter int unsigned LINE_W = LINE_W_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ic_read,
   input  logic [ADDR_W-1:0] ic_addr,
   output logic [LINE_W-1:0] ic_rdata,
   output logic              ic_ready,
   input  logic              dc_read,
   input  logic              dc_write,
   input  logic [ADDR_W-1:0] dc_addr,
   input  logic [LINE_W-1:0] dc_wdata,
   output logic [LINE_W-1:0] dc_rdata,
   output logic              dc_ready,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic [LINE_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic              busy
);

   state_t state;
   grant_t last_grant;
   grant_t grant;

   arb_pick u_arb_pick (
      .ic_req     (ic_read),
      .dc_req     (dc_read | dc_write),
      .last_grant (last_grant),
      .grant      (grant)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_grant <= GR_DC;
         mem_read   <= 1'b0;
         mem_write  <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         ic_rdata   <= '0;
         dc_rdata   <= '0;
         ic_ready   <= 1'b0;
         dc_ready   <= 1'b0;
         busy       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant == GR_DC) begin
                  state      <= GNT_D;
                  last_grant <= GR_DC;
                  busy       <= 1'b1;
                  mem_addr   <= dc_addr;
                  // A pending write-back goes first; a concurrent read is re-picked later.
                  if (dc_write) begin
                     mem_write <= 1'b1;
                     mem_wdata <= dc_wdata;
                  end else begin
                     mem_read  <= 1'b1;
                  end
               end else if (grant == GR_IC) begin
                  state      <= GNT_I;
                  last_grant <= GR_IC;
                  busy       <= 1'b1;
                  mem_addr   <= ic_addr;
                  mem_read   <= 1'b1;
               end
            end
            GNT_I: begin
               if (mem_ready) begin
                  state    <= RESP;
                  mem_read <= 1'b0;
                  ic_rdata <= mem_rdata;
                  ic_ready <= 1'b1;
               end
            end
            GNT_D: begin
               if (mem_ready) begin
                  state     <= RESP;
                  mem_read  <= 1'b0;
                  mem_write <= 1'b0;
                  dc_ready  <= 1'b1;
                  if (!mem_write) begin
                     dc_rdata <= mem_rdata;
                  end
               end
            end
            RESP: begin
               state    <= IDLE;
               ic_ready <= 1'b0;
               dc_ready <= 1'b0;
               busy     <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
